// File: rtl/clock_edit_controller_pkg.sv
// Shared types and constants for the clock UI edit controller.
// Holds the edit FSM states, view/field codes and per-field blink masks.
package clock_ui_pkg;

    typedef enum logic [1:0] {
        VIEW    = 2'd0,
        EDIT_F0 = 2'd1,
        EDIT_F1 = 2'd2,
        EDIT_F2 = 2'd3
    } ui_state_t;

    localparam logic [1:0] VIEW_TIME  = 2'd0;
    localparam logic [1:0] VIEW_DATE  = 2'd1;
    localparam logic [1:0] VIEW_ALARM = 2'd2;

    localparam logic [1:0] FIELD_HI   = 2'd0;
    localparam logic [1:0] FIELD_MID  = 2'd1;
    localparam logic [1:0] FIELD_LO   = 2'd2;
    localparam logic [1:0] FIELD_NONE = 2'd3;

    localparam logic [7:0] MASK_HI  = 8'h30;
    localparam logic [7:0] MASK_MID = 8'h0C;
    localparam logic [7:0] MASK_LO  = 8'h03;

    function automatic logic [1:0] field_of(ui_state_t s);
        case (s)
            EDIT_F0: return FIELD_HI;
            EDIT_F1: return FIELD_MID;
            EDIT_F2: return FIELD_LO;
            default: return FIELD_NONE;
        endcase
    endfunction

    function automatic logic [7:0] mask_of(logic [1:0] f);
        case (f)
            FIELD_HI:  return MASK_HI;
            FIELD_MID: return MASK_MID;
            FIELD_LO:  return MASK_LO;
            default:   return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/clock_edit_controller_if.sv
// Button/switch inputs and strobe/display outputs of the edit controller.
// EDIT_AUTOREPEAT_EN adds the held-key level inputs.
interface clock_edit_controller_if;
    logic       btn_mode;
    logic       btn_next;
    logic       btn_inc;
    logic       btn_dec;
    logic       sw_edit_en;
`ifdef EDIT_AUTOREPEAT_EN
    logic       key_inc_held;
    logic       key_dec_held;
`endif
    logic [1:0] view_mode;
    logic [2:0] led_view;
    logic       edit_active;
    logic [1:0] field_sel;
    logic       inc_pulse;
    logic       dec_pulse;
    logic       commit_pulse;
    logic       cancel_pulse;
    logic [7:0] blink_mask;

    modport master (
`ifdef EDIT_AUTOREPEAT_EN
        output key_inc_held, key_dec_held,
`endif
        output btn_mode, btn_next, btn_inc, btn_dec, sw_edit_en,
        input  view_mode, led_view, edit_active, field_sel,
        input  inc_pulse, dec_pulse, commit_pulse, cancel_pulse,
        input  blink_mask
    );

    modport slave (
`ifdef EDIT_AUTOREPEAT_EN
        input  key_inc_held, key_dec_held,
`endif
        input  btn_mode, btn_next, btn_inc, btn_dec, sw_edit_en,
        output view_mode, led_view, edit_active, field_sel,
        output inc_pulse, dec_pulse, commit_pulse, cancel_pulse,
        output blink_mask
    );
endinterface

// File: rtl/clock_edit_controller_timer.sv
// Wrap counter 0..N-1 with synchronous clear; phase toggles on each wrap.
// Used for the digit blink and for the autorepeat cadence.
module ui_blink_timer #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic phase
);
    localparam int W = (N > 1) ? $clog2(N) : 1;

    logic [W-1:0] cnt;

    // count up, wrap at N-1 and flip the phase
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == W'(N - 1)) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + W'(1);
        end
    end
endmodule

// File: rtl/clock_edit_controller.sv
// Clock UI sequencer: view select, field edit FSM, strobes and blink mask.
// Optional EDIT_AUTOREPEAT_EN: held inc/dec keys generate repeat strobes.
module clock_edit_controller
    import clock_ui_pkg::*;
#(
    parameter int BLINK_HALF  = 25_000_000,
    parameter int TIMEOUT_CYC = 500_000_000
) (
    input  logic CLOCK_50,
    input  logic RESET,
    clock_edit_controller_if.slave ui
);
    localparam int TW = $clog2(TIMEOUT_CYC);

    ui_state_t  state, n_state;
    logic [1:0] view, n_view;
    logic       n_inc, n_dec, n_commit, n_cancel, tclr;
    logic [TW-1:0] tcnt;
    logic       blk_clr, phase;
    logic       rep_fire, rep_up, rep_hold;

`ifdef EDIT_AUTOREPEAT_EN
    localparam int REP_Q = (BLINK_HALF / 4 > 0) ? BLINK_HALF / 4 : 1;

    logic       rep_phase, rep_phase_q, rep_tick;
    logic [1:0] rep_cnt;

    assign rep_up   = ui.key_inc_held && !ui.key_dec_held;
    assign rep_hold = (state != VIEW) && (ui.key_inc_held ^ ui.key_dec_held);
    assign rep_tick = rep_hold && (rep_phase != rep_phase_q);
    assign rep_fire = rep_tick && (rep_cnt == 2'd3);

    ui_blink_timer #(.N(REP_Q)) u_rep (
        .clk   (CLOCK_50),
        .rst   (RESET),
        .clr   (!rep_hold),
        .phase (rep_phase)
    );

    // first repeat after four quarter-periods, then one per quarter
    always_ff @(posedge CLOCK_50) begin
        if (RESET || !rep_hold) begin
            rep_cnt     <= 2'd0;
            rep_phase_q <= 1'b0;
        end else begin
            rep_phase_q <= rep_phase;
            if (rep_tick && rep_cnt != 2'd3) rep_cnt <= rep_cnt + 2'd1;
        end
    end
`else
    assign rep_up   = 1'b0;
    assign rep_hold = 1'b0;
    assign rep_fire = 1'b0;
`endif

    // next state, view and strobes with mode > next > inc/dec priority
    always_comb begin
        n_state  = state;
        n_view   = view;
        n_inc    = 1'b0;
        n_dec    = 1'b0;
        n_commit = 1'b0;
        n_cancel = 1'b0;
        tclr     = 1'b0;
        if (state == VIEW) begin
            if (ui.btn_mode)
                n_view = (view == VIEW_ALARM) ? VIEW_TIME : view + 2'd1;
            else if (ui.btn_next && ui.sw_edit_en)
                n_state = EDIT_F0;
        end else if (!ui.sw_edit_en || ui.btn_mode) begin
            n_cancel = 1'b1;
            n_state  = VIEW;
        end else if (ui.btn_next) begin
            tclr = 1'b1;
            case (state)
                EDIT_F0: n_state = EDIT_F1;
                EDIT_F1: n_state = EDIT_F2;
                default: begin
                    n_commit = 1'b1;
                    n_state  = VIEW;
                end
            endcase
        end else if (ui.btn_inc || ui.btn_dec) begin
            tclr  = 1'b1;
            n_inc = ui.btn_inc && !ui.btn_dec;
            n_dec = ui.btn_dec && !ui.btn_inc;
        end else if (rep_fire) begin
            tclr  = 1'b1;
            n_inc = rep_up;
            n_dec = !rep_up;
        end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
            n_cancel = 1'b1;
            n_state  = VIEW;
        end
    end

    assign blk_clr = (n_state != state) || (n_state == VIEW) || rep_hold;

    ui_blink_timer #(.N(BLINK_HALF)) u_blink (
        .clk   (CLOCK_50),
        .rst   (RESET),
        .clr   (blk_clr),
        .phase (phase)
    );

    // state, view, strobes and idle timeout register
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state           <= VIEW;
            view            <= VIEW_TIME;
            ui.led_view     <= 3'b001;
            ui.inc_pulse    <= 1'b0;
            ui.dec_pulse    <= 1'b0;
            ui.commit_pulse <= 1'b0;
            ui.cancel_pulse <= 1'b0;
            tcnt            <= '0;
        end else begin
            state           <= n_state;
            view            <= n_view;
            ui.led_view     <= 3'b001 << n_view;
            ui.inc_pulse    <= n_inc;
            ui.dec_pulse    <= n_dec;
            ui.commit_pulse <= n_commit;
            ui.cancel_pulse <= n_cancel;
            if (tclr || n_state != state || n_state == VIEW)
                tcnt <= '0;
            else
                tcnt <= tcnt + TW'(1);
        end
    end

    assign ui.view_mode   = view;
    assign ui.edit_active = (state != VIEW);
    assign ui.field_sel   = field_of(state);
    assign ui.blink_mask  = phase ? mask_of(field_of(state)) : 8'h00;
endmodule

// File: tb/tb_clock_edit_controller.sv
// Self-checking bench for clock_edit_controller (BLINK_HALF=4, TIMEOUT_CYC=20).
// Cycle model compared every cycle, plus directed literal checks.
module tb_clock_edit_controller;
    localparam int BH = 4;
    localparam int TO = 20;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    clock_edit_controller_if ui();

    clock_edit_controller #(.BLINK_HALF(BH), .TIMEOUT_CYC(TO)) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .ui       (ui)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // model: field -1 means viewing; idle = cycles since last button;
    // age = cycles spent in the current field
    int m_view, m_field, m_idle, m_age;
    bit m_inc, m_dec, m_commit, m_cancel;

    always @(posedge clk) begin
        m_inc = 0; m_dec = 0; m_commit = 0; m_cancel = 0;
        if (rst) begin
            m_view = 0; m_field = -1; m_idle = 0; m_age = 0;
        end else if (m_field < 0) begin
            if (ui.btn_mode) m_view = (m_view + 1) % 3;
            else if (ui.btn_next && ui.sw_edit_en) begin
                m_field = 0; m_idle = 0; m_age = 0;
            end
        end else if (!ui.sw_edit_en || ui.btn_mode) begin
            m_cancel = 1; m_field = -1;
        end else if (ui.btn_next) begin
            m_idle = 0; m_age = 0;
            if (m_field == 2) begin
                m_commit = 1; m_field = -1;
            end else m_field++;
        end else begin
            if (ui.btn_inc || ui.btn_dec) begin
                m_idle = 0;
                m_inc = ui.btn_inc && !ui.btn_dec;
                m_dec = ui.btn_dec && !ui.btn_inc;
            end else if (m_idle == TO - 1) begin
                m_cancel = 1; m_field = -1;
            end else m_idle++;
            m_age++;
        end
    end

    // compare every cycle against the model
    always @(negedge clk) begin
        logic [7:0] e_mask;
        e_mask = 8'h00;
        if (m_field >= 0 && ((m_age / BH) % 2) == 1)
            e_mask = 8'h30 >> (2 * m_field);
        chk("view_mode", 32'(ui.view_mode), 32'(m_view));
        chk("led_view", 32'(ui.led_view), 32'(1 << m_view));
        chk("edit_active", 32'(ui.edit_active), 32'(m_field >= 0));
        chk("field_sel", 32'(ui.field_sel), 32'(m_field < 0 ? 3 : m_field));
        chk("inc_pulse", 32'(ui.inc_pulse), 32'(m_inc));
        chk("dec_pulse", 32'(ui.dec_pulse), 32'(m_dec));
        chk("commit_pulse", 32'(ui.commit_pulse), 32'(m_commit));
        chk("cancel_pulse", 32'(ui.cancel_pulse), 32'(m_cancel));
        chk("blink_mask", 32'(ui.blink_mask), 32'(e_mask));
    end

    task automatic drive(input logic m, n, i, d, s);
        ui.btn_mode = m; ui.btn_next = n;
        ui.btn_inc = i;  ui.btn_dec = d;
        ui.sw_edit_en = s;
        @(negedge clk);
        ui.btn_mode = 0; ui.btn_next = 0;
        ui.btn_inc = 0;  ui.btn_dec = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        ui.btn_mode = 0; ui.btn_next = 0;
        ui.btn_inc = 0;  ui.btn_dec = 0;
        ui.sw_edit_en = 0;
`ifdef EDIT_AUTOREPEAT_EN
        ui.key_inc_held = 0; ui.key_dec_held = 0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("L_rst_view", 32'(ui.view_mode), 0);
        chk("L_rst_led", 32'(ui.led_view), 32'h1);
        chk("L_rst_field", 32'(ui.field_sel), 3);
        chk("L_rst_mask", 32'(ui.blink_mask), 0);

        drive(1, 0, 0, 0, 0);
        chk("L_mode1_view", 32'(ui.view_mode), 1);
        chk("L_mode1_led", 32'(ui.led_view), 32'h2);
        idle(1);
        drive(1, 0, 0, 0, 0);
        chk("L_mode2_view", 32'(ui.view_mode), 2);
        chk("L_mode2_led", 32'(ui.led_view), 32'h4);
        idle(1);
        drive(1, 0, 0, 0, 0);
        chk("L_mode3_view", 32'(ui.view_mode), 0);
        chk("L_mode3_led", 32'(ui.led_view), 32'h1);
        idle(1);

        drive(0, 1, 0, 0, 0);
        chk("L_next_noen", 32'(ui.edit_active), 0);
        drive(0, 1, 0, 0, 1);
        chk("L_enter_edit", 32'(ui.edit_active), 1);
        chk("L_enter_field", 32'(ui.field_sel), 0);
        drive(0, 0, 1, 0, 1);
        chk("L_inc_f0", 32'(ui.inc_pulse), 1);
        chk("L_inc_f0_sel", 32'(ui.field_sel), 0);
        drive(0, 1, 0, 0, 1);
        chk("L_f1_sel", 32'(ui.field_sel), 1);
        drive(0, 0, 0, 1, 1);
        chk("L_dec_f1", 32'(ui.dec_pulse), 1);
        chk("L_dec_f1_sel", 32'(ui.field_sel), 1);
        drive(0, 1, 0, 0, 1);
        chk("L_f2_sel", 32'(ui.field_sel), 2);
        drive(0, 1, 0, 0, 1);
        chk("L_commit", 32'(ui.commit_pulse), 1);
        chk("L_commit_sel", 32'(ui.field_sel), 3);
        chk("L_commit_edit", 32'(ui.edit_active), 0);

        drive(0, 1, 0, 0, 1);
        drive(0, 1, 0, 0, 1);
        chk("L_blink0", 32'(ui.blink_mask), 0);
        idle(4);
        chk("L_blink1", 32'(ui.blink_mask), 32'h0C);
        idle(4);
        chk("L_blink2", 32'(ui.blink_mask), 0);
        idle(11);
        chk("L_to_before", 32'(ui.cancel_pulse), 0);
        chk("L_to_before_edit", 32'(ui.edit_active), 1);
        idle(1);
        chk("L_to_cancel", 32'(ui.cancel_pulse), 1);
        chk("L_to_edit", 32'(ui.edit_active), 0);
        idle(1);
        chk("L_to_after", 32'(ui.edit_active), 0);

        drive(0, 1, 0, 0, 1);
        drive(1, 0, 1, 0, 1);
        chk("L_modeinc_cancel", 32'(ui.cancel_pulse), 1);
        chk("L_modeinc_inc", 32'(ui.inc_pulse), 0);
        chk("L_modeinc_view", 32'(ui.view_mode), 0);

        drive(0, 1, 0, 0, 1);
        drive(0, 0, 1, 1, 1);
        chk("L_incdec_inc", 32'(ui.inc_pulse), 0);
        chk("L_incdec_dec", 32'(ui.dec_pulse), 0);
        chk("L_incdec_edit", 32'(ui.edit_active), 1);

        drive(0, 1, 0, 0, 1);
        drive(0, 1, 0, 0, 1);
        chk("L_f2_again", 32'(ui.field_sel), 2);
        drive(0, 1, 0, 0, 0);
        chk("L_swoff_cancel", 32'(ui.cancel_pulse), 1);
        chk("L_swoff_commit", 32'(ui.commit_pulse), 0);

        drive(0, 1, 0, 0, 1);
        drive(0, 1, 0, 0, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("L_rstmid_edit", 32'(ui.edit_active), 0);
        chk("L_rstmid_field", 32'(ui.field_sel), 3);
        chk("L_rstmid_cancel", 32'(ui.cancel_pulse), 0);
        chk("L_rstmid_led", 32'(ui.led_view), 32'h1);
        rst = 1'b0;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/clock_edit_controller.md
Name: clock_edit_controller

Overview:
- Sequences the user interface of the digital clock: selects the view (time/date/alarm), runs the field-by-field edit FSM, and issues single-cycle increment/decrement/commit/cancel strobes to the timekeeping datapath.
- Produces the blink mask for the HEX digits under edit and the one-hot view LEDs.
- Sits between the debounced push-button pulses and switch inputs and the time/date/alarm registers inside the main manager.

Parameters:
- BLINK_HALF, 25_000_000, clock cycles per blink half-period (0.5 s at 50 MHz)
- TIMEOUT_CYC, 500_000_000, idle cycles in edit before auto-cancel (10 s)

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- RESET  in  1  synchronous, active-high reset
- btn_mode  in  1  one-cycle pulse, debounced
- btn_next  in  1  one-cycle pulse, debounced
- btn_inc  in  1  one-cycle pulse, debounced
- btn_dec  in  1  one-cycle pulse, debounced
- sw_edit_en  in  1  level; edit permitted when 1
- view_mode  out  2  0=time, 1=date, 2=alarm
- led_view  out  3  one-hot of view_mode (bit n = mode n)
- edit_active  out  1  high in any EDIT state
- field_sel  out  2  0=high pair (hh/dd), 1=mid (mm/MM), 2=low (ss/YY); 3 when not editing
- inc_pulse  out  1  one-cycle increment strobe for field_sel
- dec_pulse  out  1  one-cycle decrement strobe for field_sel
- commit_pulse  out  1  one-cycle: latch edited values into view_mode target
- cancel_pulse  out  1  one-cycle: discard edit
- blink_mask  out  8  bit i = blank HEXi this cycle

Behaviour:
- All outputs registered; response appears on the cycle after the input pulse (latency 1).
- Reset values: state VIEW, view_mode=0, led_view=3'b001, edit_active=0, field_sel=3, all pulses 0, blink_mask=0, counters 0.
- Per-cycle button priority: btn_mode > btn_next > inc/dec. Lower-priority pulses in the same cycle are dropped. btn_inc and btn_dec together produce no strobe.
- States: VIEW, EDIT_F0, EDIT_F1, EDIT_F2.
- VIEW transitions:
  - btn_mode: view_mode 0→1→2→0.
  - btn_next with sw_edit_en=1: →EDIT_F0. With sw_edit_en=0 it is ignored.
  - inc/dec ignored.
- EDIT_Fn transitions:
  - btn_next: EDIT_F0→F1, F1→F2. From F2: commit_pulse=1 and →VIEW.
  - btn_inc/btn_dec: inc_pulse/dec_pulse=1 with field_sel=n; state unchanged.
  - btn_mode: cancel_pulse=1, →VIEW; view_mode unchanged.
  - sw_edit_en=0: cancel_pulse=1, →VIEW. This takes precedence over all buttons in that cycle.
  - Timeout: counter cleared on edit entry and on every accepted button pulse, otherwise increments. On reaching TIMEOUT_CYC-1: cancel_pulse=1, →VIEW.
- view_mode is frozen while edit_active=1.
- Blink:
  - Phase counter runs 0..BLINK_HALF-1 and wraps, toggling phase on wrap.
  - Counter and phase are reset to 0/visible on edit entry and on each field change, so the new field is shown immediately.
  - Phase 1 blanks the field's pair: F0→bits 5:4, F1→3:2, F2→1:0.
  - blink_mask=0 in VIEW.
- RESET mid-edit: immediate return to reset values; no cancel_pulse.
- Counter widths sized with $clog2 of the parameters; no overflow is reachable.

Optional Feature:
- Macro: EDIT_AUTOREPEAT_EN.
- Defined:
  - Adds inputs key_inc_held and key_dec_held (levels).
  - In EDIT, a held level without the opposite level gives a first repeat strobe after BLINK_HALF cycles, then one every BLINK_HALF/4 cycles.
  - Releasing the level stops repeats; blink phase is held visible while repeating.
- Undefined: ports absent; only the pulse inputs generate strobes.

Decomposition:
- Package clock_ui_pkg:
  - state enum (VIEW, EDIT_F0..F2)
  - view codes (VIEW_TIME=0, VIEW_DATE=1, VIEW_ALARM=2)
  - field codes and FIELD_NONE=3
  - per-field 8-bit blink masks
- One sub-module, ui_blink_timer: parameterised wrap counter with synchronous clear; outputs phase.
- Both the blink counter and the autorepeat counter instantiate ui_blink_timer.

Test Plan (BLINK_HALF=4, TIMEOUT_CYC=20):
- Reset, then btn_mode ×3, one pulse every 2 cycles → view_mode 1,2,0; led_view 010,100,001.
- sw_edit_en=1, btn_next, btn_inc, btn_next, btn_dec, btn_next → edit_active next cycle; inc_pulse with field_sel=0; dec_pulse with field_sel=1; commit_pulse once; back in VIEW with field_sel=3.
- In EDIT_F1, idle → blink_mask toggles 00→0C every 4 cycles; cancel_pulse exactly 20 cycles after the last button; edit_active=0 next cycle.
- In EDIT_F0, same-cycle btn_mode+btn_inc → cancel_pulse only, no inc_pulse. Same-cycle btn_inc+btn_dec → neither strobe.
- In EDIT_F2, drop sw_edit_en coincident with btn_next → cancel_pulse=1, commit_pulse=0.
- In EDIT_F1, assert RESET → all outputs at reset values next cycle; no cancel_pulse.
